lbist_prpg: RTL and testbench
=============================

# lbist_prpg

Parametrised pseudo-random pattern generator and signature register for the LBIST controller. A Fibonacci LFSR of configurable width and polynomial, with seed load, a programmable pattern count and a start/busy/done handshake. An optional MISR mode compacts response data into a signature. It supersedes the fixed 8-bit free-running LFSR: the defaults reproduce that generator's polynomial and all-ones start state.

## Interface
- WIDTH, 8, register width (4..32)
- POLY, 8'hB8, feedback tap mask; bit i set = q[i] XORed into feedback
- SEED, all ones, reset value and zero-seed substitute
- CNT_W, 16, width of pattern counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE/DONE)
- seed_load  in  1  load seed_in into register (sampled in IDLE/DONE)
- seed_in  in  WIDTH  seed value
- num_patterns  in  CNT_W  patterns per run, sampled with start
- mode  in  1  0 = PRPG, 1 = MISR; sampled with start, held for run
- misr_in  in  WIDTH  response data compacted per RUN cycle in MISR mode
- hold  in  1  pause run; freezes register and counter
- pattern  out  WIDTH  register contents (pattern in PRPG, signature in MISR/DONE)
- pattern_valid  out  1  pattern is a new valid pattern this cycle
- busy  out  1  state == RUN
- done  out  1  state == DONE (level)

## Operation
- States: IDLE, RUN, DONE. reset low → IDLE, q=SEED, count=0, mode_r=0; outputs pattern=SEED, pattern_valid=0, busy=0, done=0. Reset is effective immediately, including mid-run.
- Feedback: fb = XOR-reduce(q & POLY). Advance: PRPG q <= {q[WIDTH-2:0], fb}; MISR q <= {q[WIDTH-2:0], fb} ^ misr_in.
- IDLE/DONE, seed_load=1, start=0: q <= seed_in, state → IDLE. In PRPG mode (current mode input), a seed_in of 0 loads SEED (lockup guard); MISR accepts 0.
- IDLE/DONE, start=1, num_patterns≠0: state → RUN, count <= num_patterns, mode_r <= mode. If seed_load is also 1, q <= seed_in (same zero rule) in that cycle, so the first pattern is the new seed. Otherwise q is kept, and a run from DONE continues the sequence.
- IDLE/DONE, start=1, num_patterns=0: state → DONE, no advance, q unchanged (seed_load still honoured).
- RUN, hold=0: pattern_valid=1 with pattern=q. q advances and count decrements. When count==1, state → DONE. Exactly num_patterns valid cycles per run.
- RUN, hold=1: pattern_valid=0; q, count and state frozen; misr_in ignored.
- start, seed_load, mode, num_patterns ignored while in RUN; no abort other than reset.
- DONE: q holds the final value (next state after the last valid pattern); done=1 until start or seed_load.

## Timing
- All state registered; pattern_valid, busy, done decoded from state (pattern_valid also gated by ~hold), no input-to-output combinational path except hold→pattern_valid.
- start at edge k → busy=1 and first valid pattern in cycle k+1. Last valid pattern in cycle k+N (no hold). done=1 from cycle k+N+1.
- Each hold cycle extends the run by one cycle.
- seed_load at edge k → pattern=seed from cycle k+1.
- Reset deassertion: first start accepted on the first rising edge with reset high.

## Test plan
- Defaults, reset, start with num_patterns=6 → pattern_valid for 6 cycles with pattern FF, FE, FC, F8, F0, E1; then done=1, pattern=C2, busy=0.
- num_patterns=255 from reset → 255 distinct non-zero patterns, no repeat; DONE with pattern=FF (maximal length).
- seed_load with seed_in=00, mode=0 → pattern=FF. Start+seed_load with seed_in=A5, num_patterns=1 → single valid pattern A5.
- mode=1, seed_in=00, num_patterns=2, misr_in=01 both cycles → DONE with pattern=03 (01 after first cycle).
- Run of 6 with hold high in cycles 2–3 → same 6 patterns, two pattern_valid gaps, done two cycles later. num_patterns=0 → done next cycle, pattern unchanged.
- reset low mid-run (third pattern) → immediately pattern=FF, busy=0, done=0; new start after release repeats FF, FE, ...

Source files
------------

// File: rtl/lbist_prpg.sv
// LBIST pattern generator: Fibonacci LFSR with seed load, pattern count and
// start/busy/done handshake, plus an optional MISR mode for response compaction.
module lbist_prpg #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int               CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    input  logic [CNT_W-1:0] num_patterns_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] misr_in_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] pattern_o,
    output logic             pattern_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic             fb;
    logic [WIDTH-1:0] adv;
    logic [WIDTH-1:0] load_val;

    assign fb  = ^(q_q & POLY);
    assign adv = {q_q[WIDTH-2:0], fb} ^ (mode_q ? misr_in_i : '0);

    // An all-zero seed would lock a PRPG forever; a signature may start at zero.
    assign load_val = ((seed_in_i == '0) && !mode_i) ? SEED : seed_in_i;

    // NOTE: every next-state signal takes its default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_RUN: begin
                if (!hold_i) begin
                    q_d   = adv;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (seed_load_i) begin
                    q_d = load_val;
                end
                if (start_i) begin
                    if (num_patterns_i != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = num_patterns_i;
                        mode_d  = mode_i;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (seed_load_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            q_q     <= SEED;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign pattern_o       = q_q;
    assign busy_o          = (state_q == ST_RUN);
    assign pattern_valid_o = busy_o & ~hold_i;
    assign done_o          = (state_q == ST_DONE);

endmodule

// File: tb/tb_lbist_prpg.sv
// Directed self-checking bench for lbist_prpg with default parameters.
module tb_lbist_prpg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        seed_load;
    logic [7:0]  seed_in;
    logic [15:0] num_patterns;
    logic        mode;
    logic [7:0]  misr_in;
    logic        hold;
    logic [7:0]  pattern;
    logic        pattern_valid;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    lbist_prpg dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .seed_load_i     (seed_load),
        .seed_in_i       (seed_in),
        .num_patterns_i  (num_patterns),
        .mode_i          (mode),
        .misr_in_i       (misr_in),
        .hold_i          (hold),
        .pattern_o       (pattern),
        .pattern_valid_o (pattern_valid),
        .busy_o          (busy),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        seed_load = 1'b0;
        seed_in = 8'h00;
        num_patterns = 16'd0;
        mode = 1'b0;
        misr_in = 8'h00;
        hold = 1'b0;
    endtask

    task automatic launch(input logic [15:0] n, input logic m, input logic ld, input logic [7:0] sd);
        start = 1'b1;
        num_patterns = n;
        mode = m;
        seed_load = ld;
        seed_in = sd;
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic expect_valid(input string tag, input logic [7:0] p);
        check({tag, "_valid"}, pattern_valid, 1'b1);
        check({tag, "_pat"}, pattern, p);
        tick();
    endtask

    task automatic expect_done(input string tag, input logic [7:0] p);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pat"}, pattern, p);
    endtask

    logic [7:0] seq6 [6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    bit seen [256];

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_pat", pattern, 8'hFF);
        check("rst_valid", pattern_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run of 6 from the reset seed.
        launch(16'd6, 1'b0, 1'b0, 8'h00);
        check("run6_busy", busy, 1'b1);
        for (int i = 0; i < 6; i++) expect_valid("run6", seq6[i]);
        expect_done("run6_end", 8'hC2);

        // Zero seed in PRPG mode substitutes the default seed.
        seed_load = 1'b1;
        seed_in = 8'h00;
        tick();
        idle_inputs();
        #1;
        check("zseed_pat", pattern, 8'hFF);
        check("zseed_done", done, 1'b0);

        // Maximal-length sequence.
        foreach (seen[i]) seen[i] = 1'b0;
        launch(16'd255, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 255; i++) begin
            check("max_valid", pattern_valid, 1'b1);
            check("max_nonzero_distinct", {31'd0, (pattern == 8'h00) || seen[pattern]}, 32'd0);
            seen[pattern] = 1'b1;
            tick();
        end
        expect_done("max_end", 8'hFF);

        // Start with seed load, single pattern.
        launch(16'd1, 1'b0, 1'b1, 8'hA5);
        expect_valid("a5", 8'hA5);
        expect_done("a5_end", 8'h4A);

        // MISR compaction from a zero signature.
        seed_load = 1'b1;
        seed_in = 8'h00;
        mode = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("misr_seed", pattern, 8'h00);
        start = 1'b1;
        num_patterns = 16'd2;
        mode = 1'b1;
        misr_in = 8'h01;
        tick();
        start = 1'b0;
        mode = 1'b0;
        #1;
        check("misr_c1_valid", pattern_valid, 1'b1);
        check("misr_c1_pat", pattern, 8'h00);
        tick();
        check("misr_c2_pat", pattern, 8'h01);
        tick();
        idle_inputs();
        #1;
        expect_done("misr_end", 8'h03);

        // Zero pattern count goes straight to DONE.
        launch(16'd0, 1'b0, 1'b0, 8'h00);
        expect_done("zero_cnt", 8'h03);

        // Hold during run cycles 2 and 3.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        launch(16'd6, 1'b0, 1'b0, 8'h00);
        expect_valid("hold_c1", 8'hFF);
        for (int i = 0; i < 2; i++) begin
            hold = 1'b1;
            #1;
            check("hold_gap_valid", pattern_valid, 1'b0);
            check("hold_gap_busy", busy, 1'b1);
            check("hold_gap_pat", pattern, 8'hFE);
            tick();
        end
        hold = 1'b0;
        #1;
        for (int i = 1; i < 6; i++) expect_valid("hold_run", seq6[i]);
        expect_done("hold_end", 8'hC2);

        // Reset in the middle of a run.
        launch(16'd6, 1'b0, 1'b1, 8'hFF);
        expect_valid("mid_c1", 8'hFF);
        expect_valid("mid_c2", 8'hFE);
        check("mid_c3_pat", pattern, 8'hFC);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pat", pattern, 8'hFF);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_valid", pattern_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(16'd6, 1'b0, 1'b0, 8'h00);
        expect_valid("rerun_c1", 8'hFF);
        expect_valid("rerun_c2", 8'hFE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
